// File: rtl/game_tick_generator_pkg.sv
// Shared types and constants for the game tick generator.
//   tick_state_t : run-control state (IDLE / RUN / PAUSED); 2'd3 is illegal
//                  and recovers to IDLE.
//   SIM_DIV      : divider used when TICK_SIM_FAST_EN is defined.
package tick_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } tick_state_t;

   localparam int unsigned SIM_DIV = 16;

endpackage

// File: rtl/game_tick_generator_if.sv
// Control/status bundle between the button logic, the tick generator and
// the downstream BCD timer / display.
//   start, pause   : synchronised button levels (master drives)
//   tick           : one-cycle enable pulse for the timer (slave drives)
//   running, blink : status for the display (slave drives)
interface game_tick_generator_if;

   logic start;
   logic pause;
   logic tick;
   logic running;
   logic blink;

   modport master (
      output start,
      output pause,
      input  tick,
      input  running,
      input  blink
   );

   modport slave (
      input  start,
      input  pause,
      output tick,
      output running,
      output blink
   );

endinterface

// File: rtl/game_tick_generator_rise_detect.sv
// Rising-edge detector: one flop holding the previous sample plus an AND.
//   clock : clock
//   reset : synchronous active-high reset (clears the previous sample, so a
//           level already high after reset counts as a rising edge)
//   level : synchronised input level
//   rise  : high for the cycle in which level is 1 and was 0 last cycle
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clock) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/game_tick_generator.sv
// Run/pause-controlled rate divider producing the one-cycle game tick.
//   clock : sole clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : slave side of game_tick_generator_if
//           (start/pause in; tick/running/blink out)
// Parameters: CLK_HZ, TICK_HZ; DIV = CLK_HZ / TICK_HZ (even, >= 4).
// Build option: define TICK_SIM_FAST_EN to force DIV = SIM_DIV (16).
module game_tick_generator
   import tick_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   game_tick_generator_if.slave  bus
);

`ifdef TICK_SIM_FAST_EN
   localparam int unsigned DIV = SIM_DIV;
`else
   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
`endif
   localparam int unsigned CW = $clog2(DIV);

   tick_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic          start_rise, pause_rise;
   logic          running;

   rise_detect u_start_rise (
      .clock (clock),
      .reset (reset),
      .level (bus.start),
      .rise  (start_rise)
   );

   rise_detect u_pause_rise (
      .clock (clock),
      .reset (reset),
      .level (bus.pause),
      .rise  (pause_rise)
   );

   // State register (counter and registered tick travel with it).
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
      end
   end

   // Next-state logic. In RUN a pause edge freezes the count before the
   // wrap check, so a pause on the terminal count swallows that tick and
   // it fires on the first RUN edge after resume.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_rise) state_d = RUN;
         end
         RUN: begin
            if (pause_rise) begin
               state_d = PAUSED;
            end else if (cnt_q == CW'(DIV - 1)) begin
               cnt_d  = '0;
               tick_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PAUSED: begin
            if (start_rise) state_d = RUN;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: from registered state only.
   always_comb begin
      running     = (state_q == RUN);
      bus.running = running;
      bus.blink   = running && (cnt_q < CW'(DIV / 2));
      bus.tick    = tick_q;
   end

endmodule

// File: tb/tb_game_tick_generator.sv
module tb_game_tick_generator;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   game_tick_generator_if bus ();

   // CLK_HZ/TICK_HZ chosen so DIV = 16 with or without TICK_SIM_FAST_EN.
   game_tick_generator #(
      .CLK_HZ  (16),
      .TICK_HZ (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance n rising edges; return 1 time unit after the last one, where
   // outputs are sampled and inputs are changed.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   // Start pulse sampled at the next edge (E0); returns after E0 with start low.
   task automatic start_pulse();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      step(3);
      reset = 1'b0;
      step(1);
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 000", {bus.tick, bus.running, bus.blink});
      end
      for (int k = 0; k < 100; k++) begin
         step(1);
         vectors++;
         if ({bus.tick, bus.running} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_tick cycle %0d: tick,running=%b expected 00", k, {bus.tick, bus.running});
         end
      end
   endtask

   task automatic test_run();
      logic [2:0] exp;
      do_reset();
      start_pulse();
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b011) begin
         miscompares++;
         $display("FAIL run_e0: got %b expected 011", {bus.tick, bus.running, bus.blink});
      end
      // After edge E_k: cnt = k mod 16, tick only after E16/E32/E48.
      for (int k = 1; k <= 49; k++) begin
         step(1);
         exp = {(k % 16 == 0), 1'b1, ((k % 16) < 8)};
         vectors++;
         if ({bus.tick, bus.running, bus.blink} !== exp) begin
            miscompares++;
            $display("FAIL run_e%0d: tick,running,blink=%b expected %b", k, {bus.tick, bus.running, bus.blink}, exp);
         end
      end
   endtask

   task automatic test_pause_resume();
      logic [2:0] exp;
      int         c;
      do_reset();
      start_pulse();
      step(5);                    // cnt = 5
      bus.pause = 1'b1;
      step(1);                    // paused, cnt frozen at 5
      for (int k = 0; k < 40; k++) begin
         vectors++;
         if ({bus.tick, bus.running, bus.blink} !== 3'b000) begin
            miscompares++;
            $display("FAIL paused_cycle%0d: got %b expected 000", k, {bus.tick, bus.running, bus.blink});
         end
         if (k < 39) step(1);
      end
      bus.start = 1'b1;
      step(1);                    // resumed, cnt 5
      bus.start = 1'b0;
      bus.pause = 1'b0;
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b011) begin
         miscompares++;
         $display("FAIL resume_edge: got %b expected 011", {bus.tick, bus.running, bus.blink});
      end
      for (int j = 1; j <= 12; j++) begin
         step(1);
         c   = (5 + j) % 16;
         exp = {(j == 11), 1'b1, (c < 8)};
         vectors++;
         if ({bus.tick, bus.running, bus.blink} !== exp) begin
            miscompares++;
            $display("FAIL resume_plus%0d: got %b expected %b", j, {bus.tick, bus.running, bus.blink}, exp);
         end
      end
   endtask

   task automatic test_pause_at_wrap();
      do_reset();
      start_pulse();
      step(15);                   // cnt = 15
      bus.pause = 1'b1;
      step(1);                    // pause wins over the wrap
      bus.pause = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({bus.tick, bus.running, bus.blink} !== 3'b000) begin
            miscompares++;
            $display("FAIL wrap_paused%0d: got %b expected 000", k, {bus.tick, bus.running, bus.blink});
         end
         step(1);
      end
      bus.start = 1'b1;
      step(1);                    // RUN, cnt 15
      bus.start = 1'b0;
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b010) begin
         miscompares++;
         $display("FAIL wrap_resume: got %b expected 010", {bus.tick, bus.running, bus.blink});
      end
      step(1);
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b111) begin
         miscompares++;
         $display("FAIL wrap_first_tick: got %b expected 111", {bus.tick, bus.running, bus.blink});
      end
      step(1);
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b011) begin
         miscompares++;
         $display("FAIL wrap_tick_width: got %b expected 011", {bus.tick, bus.running, bus.blink});
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      start_pulse();
      step(3);                    // RUN, cnt 3
      bus.start = 1'b1;
      bus.pause = 1'b1;
      step(1);                    // RUN: pause wins
      vectors++;
      if ({bus.running, bus.blink} !== 2'b00) begin
         miscompares++;
         $display("FAIL both_in_run: running,blink=%b expected 00", {bus.running, bus.blink});
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      step(1);
      bus.start = 1'b1;
      bus.pause = 1'b1;
      step(1);                    // PAUSED: start wins, cnt 3
      vectors++;
      if ({bus.running, bus.blink} !== 2'b11) begin
         miscompares++;
         $display("FAIL both_in_paused: running,blink=%b expected 11", {bus.running, bus.blink});
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      step(1);
      bus.pause = 1'b1;
      step(1);                    // PAUSED
      bus.pause = 1'b0;
      bus.start = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step(1);
         vectors++;
         if (bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL start_held%0d: running=%b expected 1", k, bus.running);
         end
      end
      bus.pause = 1'b1;           // start still held
      step(1);
      bus.pause = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL held_no_retrigger%0d: running=%b expected 0", k, bus.running);
         end
         step(1);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_pulse();
      step(15);                   // cnt = 15, tick would follow
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_mid_edge: got %b expected 000", {bus.tick, bus.running, bus.blink});
      end
      for (int k = 0; k < 20; k++) begin
         step(1);
         vectors++;
         if ({bus.tick, bus.running, bus.blink} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_after%0d: got %b expected 000", k, {bus.tick, bus.running, bus.blink});
         end
      end
   endtask

   task automatic test_start_after_reset();
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.pause = 1'b0;
      step(2);
      reset = 1'b0;
      vectors++;
      if (bus.running !== 1'b0) begin
         miscompares++;
         $display("FAIL start_during_reset: running=%b expected 0", bus.running);
      end
      step(1);                    // start_q was cleared, so this is a rise
      vectors++;
      if ({bus.tick, bus.running, bus.blink} !== 3'b011) begin
         miscompares++;
         $display("FAIL start_after_reset: got %b expected 011", {bus.tick, bus.running, bus.blink});
      end
      bus.start = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.pause   = 1'b0;
      test_reset();
      test_run();
      test_pause_resume();
      test_pause_at_wrap();
      test_simultaneous();
      test_reset_mid();
      test_start_after_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
